// File: rtl/fb_scanout_pkg.sv
// Shared types and default raster constants for the frame-buffer scanout path.
`ifndef FRAME_BUFFER_ADDR_SIZE
`define FRAME_BUFFER_ADDR_SIZE 19
`endif

package fb_scanout_pkg;

  typedef logic [23:0] Color;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Frame-buffer read port plus pixel stream; master is the scanout engine.
interface fb_scanout_if
  import fb_scanout_pkg::*;
#(
  parameter int ADDR_W = `FRAME_BUFFER_ADDR_SIZE
);

  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_valid;
  Color              fb_rd_data;
  logic              pix_valid;
  logic              pix_ready;
  Color              pix_color;
  logic              pix_sol;
  logic              pix_eof;

  modport master (
    output fb_rd_en, fb_addr, pix_valid, pix_color, pix_sol, pix_eof,
    input  fb_rd_valid, fb_rd_data, pix_ready
  );

  modport slave (
    input  fb_rd_en, fb_addr, pix_valid, pix_color, pix_sol, pix_eof,
    output fb_rd_valid, fb_rd_data, pix_ready
  );

endinterface

// File: rtl/fb_scanout_checker.sv
// Configuration and credit invariants for fb_scanout.
module fb_scanout_checker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19,
  parameter int CW         = 3
) (
  input logic        clk,
  input logic        n_rst,
  input logic [CW:0] inflight
);

  if ((longint'(H_ACTIVE) * longint'(V_ACTIVE)) > (longint'(1) << ADDR_W)) begin : g_fit_fail
    $error("fb_scanout: frame of %0d x %0d does not fit in %0d address bits",
           H_ACTIVE, V_ACTIVE, ADDR_W);
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_fail
    $error("fb_scanout: FIFO_DEPTH %0d must be a power of two >= 2", FIFO_DEPTH);
  end

  a_credit: assert property (@(posedge clk) disable iff (!n_rst)
                             inflight <= (CW+1)'(FIFO_DEPTH))
    else $error("fb_scanout: outstanding plus buffered exceeds FIFO depth");

endmodule

// File: rtl/fb_scanout_fifo.sv
// Show-ahead synchronous FIFO: head is the oldest entry whenever empty is low.
module fb_scanout_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop; a push into a full FIFO is only legal alongside a pop.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop && (count_r != CW'(0));
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= WIDTH'(0);
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/fb_scanout.sv
// Raster-order frame-buffer reader; credit-limited prefetch absorbs read latency.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = `FRAME_BUFFER_ADDR_SIZE
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  fb_scanout_if.master bus,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int XW = cnt_width(H_ACTIVE);
  localparam int YW = cnt_width(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  scan_state_e       state_r;
  scan_state_e       state_nxt_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [CW-1:0]     outs_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;

  logic [CW-1:0]     fifo_count_s;
  logic              fifo_empty_s;
  Color              fifo_head_s;
  logic [CW:0]       inflight_s;
  logic              fetch_s;
  logic              busy_s;
  logic              done_s;
  logic              issue_s;
  logic              ret_s;
  logic              pop_s;
  logic              x_last_s;
  logic              y_last_s;
  logic              eof_s;
  logic              begin_s;

  fb_scanout_fifo #(
    .WIDTH ($bits(Color)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (ret_s),
    .din   (bus.fb_rd_data),
    .pop   (pop_s),
    .head  (fifo_head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  fb_scanout_checker #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .CW         (CW)
  ) u_chk (
    .clk      (clk),
    .n_rst    (n_rst),
    .inflight (inflight_s)
  );

  // Credit, handshake and raster-position decode.
  always_comb begin
    inflight_s = {1'b0, outs_r} + {1'b0, fifo_count_s};
    issue_s    = fetch_s && (inflight_s < (CW+1)'(FIFO_DEPTH));
    ret_s      = bus.fb_rd_valid && (outs_r != CW'(0));
    pop_s      = !fifo_empty_s && bus.pix_ready;
    x_last_s   = (x_r == XW'(H_ACTIVE - 1));
    y_last_s   = (y_r == YW'(V_ACTIVE - 1));
    eof_s      = x_last_s && y_last_s;
    begin_s    = (state_r == IDLE) && start;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = FETCH;
        else       state_nxt_s = IDLE;
      end
      FETCH: begin
        if (issue_s && (rd_addr_r == LAST_ADDR)) state_nxt_s = DRAIN;
        else                                     state_nxt_s = FETCH;
      end
      DRAIN: begin
        if (pop_s && eof_s) state_nxt_s = DONE;
        else                state_nxt_s = DRAIN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    fetch_s = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_r)
      IDLE:    busy_s  = 1'b0;
      FETCH:   fetch_s = 1'b1;
      DRAIN:   fetch_s = 1'b0;
      DONE:    done_s  = 1'b1;
      default: busy_s  = 1'b0;
    endcase
  end

  // Read address and outstanding-request counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_addr_r <= ADDR_W'(0);
      outs_r    <= CW'(0);
    end else begin
      if (begin_s)      rd_addr_r <= ADDR_W'(0);
      else if (issue_s) rd_addr_r <= rd_addr_r + ADDR_W'(1);
      case ({issue_s, ret_s})
        2'b10:   outs_r <= outs_r + CW'(1);
        2'b01:   outs_r <= outs_r - CW'(1);
        default: outs_r <= outs_r;
      endcase
    end
  end

  // Output raster position, advanced on each accepted pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_r <= XW'(0);
      y_r <= YW'(0);
    end else if (begin_s) begin
      x_r <= XW'(0);
      y_r <= YW'(0);
    end else if (pop_s) begin
      if (x_last_s) begin
        x_r <= XW'(0);
        y_r <= y_last_s ? YW'(0) : y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  assign bus.fb_rd_en  = issue_s;
  assign bus.fb_addr   = rd_addr_r;
  assign bus.pix_valid = !fifo_empty_s;
  assign bus.pix_color = fifo_head_s;
  assign bus.pix_sol   = !fifo_empty_s && (x_r == XW'(0));
  assign bus.pix_eof   = !fifo_empty_s && eof_s;
  assign busy          = busy_s;
  assign frame_done    = done_s;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a 4x3 frame with a latency-modelled memory.
module tb_fb_scanout;
  import fb_scanout_pkg::*;

  localparam int H     = 4;
  localparam int V     = 3;
  localparam int N     = H * V;
  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  fb_scanout_if #(.ADDR_W(AW)) bus ();

  fb_scanout #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int addr;
    int due;
  } req_t;

  req_t q[$];
  int   last_due;

  // Memory contents: a fixed, address-dependent colour pattern.
  function automatic Color mem_color(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {8'hC3, b ^ 8'h5A, ~b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_en"},      32'(bus.fb_rd_en),  32'd0);
    check({tag, "_addr"},       32'(bus.fb_addr),   32'd0);
    check({tag, "_pix_valid"},  32'(bus.pix_valid), 32'd0);
    check({tag, "_busy"},       32'(busy),          32'd0);
    check({tag, "_frame_done"}, 32'(frame_done),    32'd0);
  endtask

  // One frame: called at a negedge in IDLE; returns at the DONE-cycle negedge
  // (or at the abort point when abort_at > 0).
  task automatic run_frame(input int lat_min, input int lat_max, input int ready_pct,
                           input int stall, input int abort_at,
                           input bit start_fetch, input bit start_done);
    int   t = 0, k = 0, nreq = 0, exp_addr = 0, buffered = 0, eof_cyc = -1;
    int   qsz, lat, due;
    bit   done = 1'b0, stop = 1'b0, hold_chk = 1'b0;
    Color held = '0;
    req_t r;
    q.delete();
    last_due = 0;
    while (!stop) begin
      start = (t == 0) || (start_fetch && (t == 3));
      qsz = q.size();
      if ((qsz > 0) && (q[0].due <= t)) begin
        r = q.pop_front();
        bus.fb_rd_valid = 1'b1;
        bus.fb_rd_data  = mem_color(r.addr);
      end else begin
        bus.fb_rd_valid = 1'b0;
        bus.fb_rd_data  = '0;
      end
      if ((stall > 0) && (t <= stall)) bus.pix_ready = 1'b0;
      else bus.pix_ready = ($urandom_range(99, 0) < 32'(ready_pct));
      #1;
      if (t == 1) begin
        check("first_req", 32'(bus.fb_rd_en), 32'd1);
        check("busy_fetch", 32'(busy), 32'd1);
      end
      check("frame_done", 32'(frame_done), 32'((eof_cyc >= 0) && (t == eof_cyc + 1)));
      if (frame_done) done = 1'b1;
      check("pix_valid", 32'(bus.pix_valid), 32'(buffered > 0));
      if (bus.fb_rd_en) begin
        check("req_addr", 32'(bus.fb_addr), 32'(exp_addr));
        check("credit", 32'((qsz + buffered) < DEPTH), 32'd1);
        lat = $urandom_range(lat_max, lat_min);
        due = (t + lat > last_due) ? t + lat : last_due + 1;
        last_due = due;
        q.push_back('{addr: int'(bus.fb_addr), due: due});
        exp_addr++;
        nreq++;
      end
      if (bus.pix_valid) begin
        if (hold_chk) check("hold_color", 32'(bus.pix_color), 32'(held));
        if (bus.pix_ready) begin
          check("pix_index", 32'(k < N), 32'd1);
          check("pix_color", 32'(bus.pix_color), 32'(mem_color(k)));
          check("pix_sol", 32'(bus.pix_sol), 32'((k % H) == 0));
          check("pix_eof", 32'(bus.pix_eof), 32'(k == N - 1));
          if (k == N - 1) eof_cyc = t;
          k++;
          buffered--;
          hold_chk = 1'b0;
        end else begin
          hold_chk = 1'b1;
          held = bus.pix_color;
        end
      end else begin
        hold_chk = 1'b0;
      end
      if (bus.fb_rd_valid) buffered++;
      if ((stall > 0) && (t == stall)) begin
        check("stall_reqs", 32'(nreq), 32'(DEPTH));
        check("stall_color", 32'(bus.pix_color), 32'(mem_color(0)));
        check("stall_pixels", 32'(k), 32'd0);
      end
      if (done) begin
        start = start_done;
        stop = 1'b1;
      end else if ((abort_at > 0) && (k == abort_at)) begin
        stop = 1'b1;
      end else if (t >= 400) begin
        stop = 1'b1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (abort_at == 0) begin
      check("frame_finished", 32'(done), 32'd1);
      check("pix_total", 32'(k), 32'(N));
      check("req_total", 32'(nreq), 32'(N));
    end else begin
      check("abort_point", 32'(k), 32'(abort_at));
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    start = 1'b0;
    bus.fb_rd_valid = 1'b0;
    #1;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    bus.fb_rd_valid = 1'b0;
    bus.fb_rd_data  = '0;
    bus.pix_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_frame(1, 1, 100, 0, 0, 1'b0, 1'b0);   // latency 1, always ready
    finish_frame();
    run_frame(5, 5, 100, 0, 0, 1'b0, 1'b0);   // latency 5
    finish_frame();
    run_frame(1, 1, 100, 20, 0, 1'b0, 1'b0);  // consumer stalled 20 cycles
    finish_frame();
    run_frame(1, 6, 50, 0, 0, 1'b0, 1'b0);    // random latency and ready
    finish_frame();
    run_frame(1, 1, 100, 0, 0, 1'b1, 1'b1);   // stray start in FETCH and DONE
    finish_frame();
    run_frame(1, 1, 100, 0, 0, 1'b0, 1'b0);   // back-to-back second frame
    finish_frame();

    run_frame(2, 2, 100, 0, 6, 1'b0, 1'b0);   // abort at pixel 6
    n_rst = 1'b0;
    start = 1'b0;
    bus.fb_rd_valid = 1'b0;
    bus.pix_ready = 1'b0;
    #1;
    check_reset("abort");
    @(negedge clk);
    check_reset("abort_next");
    n_rst = 1'b1;
    @(negedge clk);
    run_frame(1, 1, 100, 0, 0, 1'b0, 1'b0);
    finish_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
